debug_cmd_sequencer: RTL and testbench

// - Command sequencer inside the debug unit, between UART RX/TX and the MIPS pipeline.
// - Decodes host command bytes and sequences the CPU:
//   - program load into instruction memory;
//   - continuous run until halt;
//   - single step;
//   - state dump (PC, register file, data memory) streamed back over TX.
// - Sole owner of CPU enable and instruction-memory write port while debug is active.

---
 rtl/debug_pkg.sv | 43 ++++
 rtl/word_serializer.sv | 64 ++++++
 rtl/debug_cmd_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_debug_cmd_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug command sequencer: host command codes,
// FSM state encodings and dump geometry.
package debug_pkg;

    // Host command bytes
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h04;
    localparam logic [7:0] CMD_STEP = 8'h06;
    localparam logic [7:0] CMD_DUMP = 8'h07;

    // Register-file depth and dump size at the default data-memory width
    localparam int NUM_REGS          = 32;
    localparam int DMEM_ADDR_DEFAULT = 4;
    localparam int DUMP_WORDS        = 1 + NUM_REGS + 2**DMEM_ADDR_DEFAULT;

    // Main sequencer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_COUNT,
        ST_LD_BYTE,
        ST_LD_WRITE,
        ST_RUN,
        ST_STEP,
        ST_DUMP_SEL,
        ST_DUMP_WAIT,
        ST_DUMP_XMIT
    } seq_state_t;

    // Which block of CPU state the dump is currently walking
    typedef enum logic [1:0] {
        SEC_PC,
        SEC_REG,
        SEC_MEM
    } dump_sec_t;

    // Word serializer states
    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_TXWAIT
    } ser_state_t;

endpackage

// File: rtl/word_serializer.sv
// Latches one word and streams it to the UART transmitter MSB byte first,
// one byte per tx_start/tx_done handshake, then pulses done.
module word_serializer
    import debug_pkg::*;
#(
    parameter int BYTE    = 8,
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [NB_DATA-1:0] word,
    input  logic               tx_done,
    output logic [BYTE-1:0]    tx_data,
    output logic               tx_start,
    output logic               done
);

    ser_state_t         state;
    ser_state_t         next_state;
    logic [NB_DATA-1:0] shreg;
    logic [1:0]         byte_idx;

    // State register
    // NOTE: clocked blocks use non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SER_IDLE;
        else        state <= next_state;
    end

    // Next state: one start strobe per byte, wait for the transmitter before the next
    // NOTE: next_state gets a default first so this block never infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            SER_IDLE:   if (load) next_state = SER_SEND;
            SER_SEND:   next_state = SER_TXWAIT;
            SER_TXWAIT: if (tx_done) next_state = (byte_idx == 2'd3) ? SER_IDLE : SER_SEND;
            default:    next_state = SER_IDLE;
        endcase
    end

    // Shift register and byte counter: top byte is always the one on the wire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            byte_idx <= 2'd0;
        end else if (state == SER_IDLE && load) begin
            shreg    <= word;
            byte_idx <= 2'd0;
        end else if (state == SER_TXWAIT && tx_done) begin
            shreg    <= {shreg[NB_DATA-BYTE-1:0], {BYTE{1'b0}}};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Outputs decoded from state; data reads 0 while idle
    always_comb begin
        tx_start = (state == SER_SEND);
        tx_data  = (state == SER_IDLE) ? '0 : shreg[NB_DATA-1 -: BYTE];
        done     = (state == SER_TXWAIT) && tx_done && (byte_idx == 2'd3);
    end

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Debug-unit command sequencer: decodes host bytes, loads instruction memory,
// runs or single-steps the CPU and streams PC / registers / data memory back.
module debug_cmd_sequencer
    import debug_pkg::*;
#(
    parameter int BYTE      = 8,
    parameter int ADDR      = 5,
    parameter int NB_DATA   = 32,
    parameter int IMEM_ADDR = 10,
    parameter int DMEM_ADDR = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [BYTE-1:0]      i_rx_data,
    input  logic                 i_rx_done,
    output logic [BYTE-1:0]      o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic                 o_cpu_enable,
    input  logic                 i_halt,
    input  logic [NB_DATA-1:0]   i_pc,
    output logic                 o_imem_wr,
    output logic [IMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0]   o_imem_data,
    output logic [ADDR-1:0]      o_reg_addr,
    input  logic [NB_DATA-1:0]   i_reg_data,
    output logic [DMEM_ADDR-1:0] o_dmem_addr,
    input  logic [NB_DATA-1:0]   i_dmem_data,
    output logic                 o_busy
);

    localparam logic [ADDR-1:0] LAST_REG = ADDR'(NUM_REGS - 1);
    localparam logic [ADDR-1:0] LAST_MEM = ADDR'(2**DMEM_ADDR - 1);

    seq_state_t           state;
    seq_state_t           next_state;

    // Load datapath
    logic [BYTE-1:0]      ld_count;
    logic [BYTE-1:0]      ld_words;
    logic [1:0]           ld_byte;
    logic [NB_DATA-1:0]   asm_word;
    logic [IMEM_ADDR-1:0] imem_idx;
    logic                 ld_last;

    // Dump datapath
    dump_sec_t            sec;
    logic [ADDR-1:0]      idx;
    logic                 last_word;
    logic                 in_dump;
    logic                 ser_load;
    logic [NB_DATA-1:0]   ser_word;
    logic                 ser_done;

    assign ld_last   = ((ld_words + BYTE'(1)) == ld_count);
    assign last_word = (sec == SEC_MEM) && (idx == LAST_MEM);

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Next state: command decode in IDLE, RX ignored elsewhere except during LOAD
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: next_state = ST_LD_COUNT;
                        CMD_RUN:  next_state = i_halt ? ST_DUMP_SEL : ST_RUN;
                        CMD_STEP: next_state = i_halt ? ST_DUMP_SEL : ST_STEP;
                        CMD_DUMP: next_state = ST_DUMP_SEL;
                        default:  next_state = ST_IDLE;
                    endcase
                end
            end
            ST_LD_COUNT:  if (i_rx_done) next_state = (i_rx_data == '0) ? ST_IDLE : ST_LD_BYTE;
            ST_LD_BYTE:   if (i_rx_done && ld_byte == 2'd3) next_state = ST_LD_WRITE;
            ST_LD_WRITE:  next_state = ld_last ? ST_IDLE : ST_LD_BYTE;
            ST_RUN:       if (i_halt) next_state = ST_DUMP_SEL;
            ST_STEP:      next_state = ST_DUMP_SEL;
            ST_DUMP_SEL:  next_state = ST_DUMP_WAIT;
            ST_DUMP_WAIT: next_state = ST_DUMP_XMIT;
            ST_DUMP_XMIT: if (ser_done) next_state = last_word ? ST_IDLE : ST_DUMP_SEL;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Load counters and word assembly (MSB byte arrives first)
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ld_count <= '0;
            ld_words <= '0;
            ld_byte  <= 2'd0;
            asm_word <= '0;
            imem_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_rx_done && i_rx_data == CMD_LOAD) begin
                        ld_words <= '0;
                        imem_idx <= '0;
                    end
                end
                ST_LD_COUNT: begin
                    if (i_rx_done) begin
                        ld_count <= i_rx_data;
                        ld_byte  <= 2'd0;
                    end
                end
                ST_LD_BYTE: begin
                    if (i_rx_done) begin
                        asm_word <= {asm_word[NB_DATA-BYTE-1:0], i_rx_data};
                        ld_byte  <= ld_byte + 2'd1;
                    end
                end
                ST_LD_WRITE: begin
                    ld_words <= ld_words + BYTE'(1);
                    imem_idx <= imem_idx + IMEM_ADDR'(1);
                end
                default: ;
            endcase
        end
    end

    // Dump walker: PC, then registers 0..31, then data memory 0..2**DMEM_ADDR-1
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sec <= SEC_PC;
            idx <= '0;
        end else if (next_state == ST_DUMP_SEL && state != ST_DUMP_XMIT) begin
            sec <= SEC_PC;
            idx <= '0;
        end else if (state == ST_DUMP_XMIT && ser_done && !last_word) begin
            case (sec)
                SEC_PC: begin
                    sec <= SEC_REG;
                    idx <= '0;
                end
                SEC_REG: begin
                    if (idx == LAST_REG) begin
                        sec <= SEC_MEM;
                        idx <= '0;
                    end else begin
                        idx <= idx + ADDR'(1);
                    end
                end
                default: idx <= idx + ADDR'(1);
            endcase
        end
    end

    // Word to serialize: read data is valid in DUMP_WAIT, one cycle after DUMP_SEL drove the address
    always_comb begin
        ser_load = (state == ST_DUMP_WAIT);
        case (sec)
            SEC_PC:  ser_word = i_pc;
            SEC_REG: ser_word = i_reg_data;
            default: ser_word = i_dmem_data;
        endcase
    end

    word_serializer #(
        .BYTE    (BYTE),
        .NB_DATA (NB_DATA)
    ) u_word_serializer (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .load     (ser_load),
        .word     (ser_word),
        .tx_done  (i_tx_done),
        .tx_data  (o_tx_data),
        .tx_start (o_tx_start),
        .done     (ser_done)
    );

    // Outputs decoded from state; everything reads 0 while idle
    always_comb begin
        in_dump      = (state == ST_DUMP_SEL) || (state == ST_DUMP_WAIT) || (state == ST_DUMP_XMIT);
        o_cpu_enable = (state == ST_RUN) || (state == ST_STEP);
        o_imem_wr    = (state == ST_LD_WRITE);
        o_imem_addr  = o_imem_wr ? imem_idx : '0;
        o_imem_data  = o_imem_wr ? asm_word : '0;
        o_reg_addr   = (in_dump && sec == SEC_REG) ? idx : '0;
        o_dmem_addr  = (in_dump && sec == SEC_MEM) ? idx[DMEM_ADDR-1:0] : '0;
        o_busy       = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Self-checking bench for debug_cmd_sequencer: a queue-based model of the
// expected write and TX streams, CPU-side memories and a UART TX responder.
module tb_debug_cmd_sequencer;
    import debug_pkg::*;

    localparam int NDMEM       = 16;
    localparam int TOTAL_BYTES = 4 * DUMP_WORDS;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        cpu_enable;
    logic        halt;
    logic [31:0] pc;
    logic        imem_wr;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [3:0]  dmem_addr;
    logic [31:0] dmem_data;
    logic        busy;

    debug_cmd_sequencer dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_done    (tx_done),
        .o_cpu_enable (cpu_enable),
        .i_halt       (halt),
        .i_pc         (pc),
        .o_imem_wr    (imem_wr),
        .o_imem_addr  (imem_addr),
        .o_imem_data  (imem_data),
        .o_reg_addr   (reg_addr),
        .i_reg_data   (reg_data),
        .o_dmem_addr  (dmem_addr),
        .i_dmem_data  (dmem_data),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CPU-side state seen by the dump
    logic [31:0] regs [32];
    logic [31:0] dmem [NDMEM];

    // Expected streams
    logic [7:0]  exp_tx [$];
    logic [41:0] exp_wr [$];

    // Observed history (written only by the compare process)
    logic [7:0]  tx_log [$];
    logic [41:0] wr_log [$];
    int tx_cnt = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    logic tx_pending = 1'b0;

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump();
        push_word(pc);
        for (int r = 0; r < 32; r++) push_word(regs[r]);
        for (int m = 0; m < NDMEM; m++) push_word(dmem[m]);
    endtask

    // Register file and data memory: read data follows the address by one clock
    initial begin : mem_model
        logic [4:0] ra;
        logic [3:0] da;
        reg_data  = '0;
        dmem_data = '0;
        forever begin
            @(negedge clk);
            ra = reg_addr;
            da = dmem_addr;
            @(posedge clk);
            #1;
            reg_data  = regs[ra];
            dmem_data = dmem[da];
        end
    end

    // UART transmitter: finishes each byte a couple of cycles after its start strobe
    initial begin : tx_model
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && rst_n === 1'b1) begin
                @(posedge clk);
                @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Compare process: checks every meaningful output event against the model
    always @(negedge clk) begin : compare
        logic [8:0]  e_tx;
        logic [42:0] e_wr;
        if (!rst_n) begin
            check("reset_outputs",
                  64'({tx_data, tx_start, cpu_enable, imem_wr, imem_addr, imem_data,
                       reg_addr, dmem_addr, busy}), 64'd0);
            tx_pending = 1'b0;
        end else begin
            if (tx_done) tx_pending = 1'b0;
            if (tx_start) begin
                check("tx_overlap", 64'(tx_pending), 64'd0);
                tx_pending = 1'b1;
                e_tx = (exp_tx.size() > 0) ? {1'b0, exp_tx.pop_front()} : 9'h100;
                check("tx_byte", 64'({1'b0, tx_data}), 64'(e_tx));
                tx_log.push_back(tx_data);
                tx_cnt++;
            end
            if (imem_wr) begin
                e_wr = (exp_wr.size() > 0) ? {1'b0, exp_wr.pop_front()} : {1'b1, 42'd0};
                check("imem_write", 64'({1'b0, imem_addr, imem_data}), 64'(e_wr));
                wr_log.push_back({imem_addr, imem_data});
                wr_cnt++;
            end
            if (cpu_enable) en_cnt++;
        end
    end

    task automatic strobe(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strobe(b);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check(name, 64'(busy), 64'd0);
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int tx_base;
        int wr_base;
        int en_base;
        int n;

        rst_n   = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        halt    = 1'b0;
        pc      = 32'h0000_0044;
        for (int r = 0; r < 32; r++) regs[r] = {8'(r), 8'hA5, 8'(r * 3), 8'h5A};
        for (int m = 0; m < NDMEM; m++) dmem[m] = {8'hD0 + 8'(m), 8'(m), 8'h00, 8'h77};
        dmem[15] = 32'hDEAD_BEEF;

        // Reset held with random RX traffic
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 rx_data = 8'($urandom);
            rx_done = 1'($urandom_range(0, 1));
        end
        #1 rx_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_tx_count", 64'(tx_cnt), 64'd0);

        // LOAD two words
        wr_base = wr_cnt;
        exp_wr.push_back({10'd0, 32'h2001_0005});
        exp_wr.push_back({10'd1, 32'hAC02_0000});
        send_byte(CMD_LOAD);
        send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAC); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        wait_idle("load_idle", 5);
        check("load_write_count", 64'(wr_cnt - wr_base), 64'd2);
        check("load_first_write", 64'(wr_log[wr_base]), 64'({10'd0, 32'h2001_0005}));
        check("load_second_write", 64'(wr_log[wr_base + 1]), 64'({10'd1, 32'hAC02_0000}));
        check("load_queue_drained", 64'(exp_wr.size()), 64'd0);

        // RUN, halt raised once seven enabled cycles have elapsed
        en_base = en_cnt;
        tx_base = tx_cnt;
        push_dump();
        strobe(CMD_RUN);
        repeat (6) @(posedge clk);
        #1 halt = 1'b1;
        wait_idle("run_idle", 3000);
        check("run_enable_cycles", 64'(en_cnt - en_base), 64'd7);
        check("run_tx_total", 64'(tx_cnt - tx_base), 64'd196);
        check("run_pc_byte0", 64'(tx_log[tx_base]), 64'h00);
        check("run_pc_byte3", 64'(tx_log[tx_base + 3]), 64'h44);
        check("run_reg0_byte1", 64'(tx_log[tx_base + 5]), 64'hA5);
        check("run_dmem15_byte0", 64'(tx_log[tx_base + 192]), 64'hDE);
        check("run_dmem15_byte3", 64'(tx_log[tx_base + 195]), 64'hEF);
        check("run_queue_drained", 64'(exp_tx.size()), 64'd0);

        // STEP with a RUN byte arriving mid-dump (must be dropped)
        halt = 1'b0;
        pc = 32'h0000_0048;
        regs[3] = 32'h3333_3333;
        en_base = en_cnt;
        tx_base = tx_cnt;
        push_dump();
        strobe(CMD_STEP);
        repeat (100) @(posedge clk);
        strobe(CMD_RUN);
        wait_idle("step1_idle", 3000);
        repeat (5) @(negedge clk);
        check("step1_enable_cycles", 64'(en_cnt - en_base), 64'd1);
        check("step1_tx_total", 64'(tx_cnt - tx_base), 64'd196);
        check("step1_still_idle", 64'(busy), 64'd0);

        // Second STEP
        pc = 32'h0000_004C;
        dmem[0] = 32'h1234_5678;
        en_base = en_cnt;
        tx_base = tx_cnt;
        push_dump();
        strobe(CMD_STEP);
        wait_idle("step2_idle", 3000);
        check("step2_enable_cycles", 64'(en_cnt - en_base), 64'd1);
        check("step2_tx_total", 64'(tx_cnt - tx_base), 64'd196);
        check("step2_dmem0_byte0", 64'(tx_log[tx_base + 132]), 64'h12);

        // STEP while halted: dump only
        halt = 1'b1;
        en_base = en_cnt;
        tx_base = tx_cnt;
        push_dump();
        strobe(CMD_STEP);
        wait_idle("step_halted_idle", 3000);
        check("step_halted_enable_cycles", 64'(en_cnt - en_base), 64'd0);
        check("step_halted_tx_total", 64'(tx_cnt - tx_base), 64'd196);
        check("step_halted_queue_drained", 64'(exp_tx.size()), 64'd0);
        halt = 1'b0;

        // Unknown command and LOAD with zero words
        en_base = en_cnt;
        tx_base = tx_cnt;
        wr_base = wr_cnt;
        strobe(8'h55);
        wait_idle("unknown_idle", 2);
        strobe(CMD_LOAD);
        strobe(8'h00);
        wait_idle("load0_idle", 2);
        repeat (4) @(negedge clk);
        check("noop_writes", 64'(wr_cnt - wr_base), 64'd0);
        check("noop_tx", 64'(tx_cnt - tx_base), 64'd0);
        check("noop_enable", 64'(en_cnt - en_base), 64'd0);

        // Reset during the third byte of a LOAD word
        wr_base = wr_cnt;
        send_byte(CMD_LOAD);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(posedge clk);
        #1 rx_data = 8'hCC;
        rx_done = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("rst_load_busy", 64'(busy), 64'd0);
        check("rst_load_imem_wr", 64'(imem_wr), 64'd0);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hDD);
        repeat (4) @(negedge clk);
        check("rst_load_no_write", 64'(wr_cnt - wr_base), 64'd0);
        check("rst_load_idle", 64'(busy), 64'd0);

        // Reset while dump byte 50 is outstanding
        tx_base = tx_cnt;
        push_dump();
        strobe(CMD_DUMP);
        n = 0;
        while ((tx_cnt - tx_base) < 50 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("dump_reached_byte50", 64'(tx_cnt - tx_base), 64'd50);
        #2 rst_n = 1'b0;
        #1 check("rst_dump_tx_start", 64'(tx_start), 64'd0);
        check("rst_dump_busy", 64'(busy), 64'd0);
        exp_tx.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_dump_no_more_tx", 64'(tx_cnt - tx_base), 64'd50);
        check("rst_dump_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
